// File: rtl/acp_bram_slave.sv
// AXI4-Lite slave that buffers the ADC capture write stream in on-chip RAM, serves it back
// over AXI4-Lite reads and strobes `half` when the last word of either buffer half is written.
module acp_bram_slave #(
  parameter logic [31:0] C_S00_AXI_BASE_ADDR  = 32'h4000_0000,
  parameter int          C_S00_AXI_ADDR_WIDTH = 32,
  parameter int          C_S00_AXI_DATA_WIDTH = 32,
  parameter int          C_S00_AXI_DEPTH      = 1024
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic                              half,
  output logic                              half_sel,
  output logic                              wr_err
);
  localparam int AW    = C_S00_AXI_ADDR_WIDTH;
  localparam int DW    = C_S00_AXI_DATA_WIDTH;
  localparam int NB    = DW / 8;
  localparam int IDX_W = $clog2(C_S00_AXI_DEPTH);

  localparam logic [AW-1:0]    BASE    = AW'(C_S00_AXI_BASE_ADDR);
  localparam logic [AW-1:0]    SPAN    = AW'(4 * C_S00_AXI_DEPTH);
  localparam logic [IDX_W-1:0] LAST_LO = IDX_W'(C_S00_AXI_DEPTH / 2 - 1);
  localparam logic [IDX_W-1:0] LAST_HI = IDX_W'(C_S00_AXI_DEPTH - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_EXEC = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_FETCH = 2'd1;
  localparam logic [1:0] R_RESP  = 2'd2;

  logic [DW-1:0] mem [C_S00_AXI_DEPTH];

  logic [1:0]    w_state, r_state;
  logic          init_done;
  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [DW-1:0] w_data;
  logic [NB-1:0] w_strb;

  logic             aw_hs, w_hs, ar_hs;
  logic [AW-1:0]    aw_off, ar_off;
  logic             aw_in_range, ar_in_range;
  logic [IDX_W-1:0] aw_idx, ar_idx;

  logic unused_prot;
  assign unused_prot = ^{s00_axi_awprot, s00_axi_arprot};

  // Addresses below BASE wrap to a huge offset and so fall out of range too.
  assign aw_off      = aw_addr - BASE;
  assign ar_off      = ar_addr - BASE;
  assign aw_in_range = aw_off < SPAN;
  assign ar_in_range = ar_off < SPAN;
  assign aw_idx      = aw_off[IDX_W+1:2];
  assign ar_idx      = ar_off[IDX_W+1:2];

  assign s00_axi_awready = init_done && (w_state == W_IDLE) && !aw_held;
  assign s00_axi_wready  = init_done && (w_state == W_IDLE) && !w_held;
  assign s00_axi_arready = init_done && (r_state == R_IDLE);

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      init_done      <= 1'b0;
      w_state        <= W_IDLE;
      aw_held        <= 1'b0;
      w_held         <= 1'b0;
      aw_addr        <= '0;
      w_data         <= '0;
      w_strb         <= '0;
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
      half           <= 1'b0;
      half_sel       <= 1'b0;
      wr_err         <= 1'b0;
    end else begin
      init_done <= 1'b1;
      half      <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr <= s00_axi_awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            w_data <= s00_axi_wdata;
            w_strb <= s00_axi_wstrb;
            w_held <= 1'b1;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) w_state <= W_EXEC;
        end
        W_EXEC: begin
          aw_held        <= 1'b0;
          w_held         <= 1'b0;
          s00_axi_bvalid <= 1'b1;
          s00_axi_bresp  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
          if (!aw_in_range) wr_err <= 1'b1;
          if (aw_in_range && (|w_strb) && (aw_idx == LAST_LO || aw_idx == LAST_HI)) begin
            half     <= 1'b1;
            half_sel <= aw_idx[IDX_W-1];
          end
          w_state <= W_RESP;
        end
        W_RESP: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
            w_state        <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the buffer array has no reset; its contents survive reset and it can map onto block RAM.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_state == W_EXEC && aw_in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (w_strb[b]) mem[aw_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  // A same-index read in R_FETCH alongside W_EXEC sees the pre-write word.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state        <= R_IDLE;
      ar_addr        <= '0;
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_addr <= s00_axi_araddr;
            r_state <= R_FETCH;
          end
        end
        R_FETCH: begin
          s00_axi_rdata  <= ar_in_range ? mem[ar_idx] : '0;
          s00_axi_rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
          s00_axi_rvalid <= 1'b1;
          r_state        <= R_RESP;
        end
        R_RESP: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acp_bram_slave.sv
// Self-checking bench for acp_bram_slave: table-driven write/read vectors plus
// hand-written sequences for latency, back-pressure, collision and reset cases.
module tb_acp_bram_slave;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot = 3'd0, arprot = 3'd0;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        half, half_sel, wr_err;

  int n_checks = 0;
  int n_errors = 0;
  int lo_cnt = 0, hi_cnt = 0, half_bad = 0;

  always #5 aclk = ~aclk;

  acp_bram_slave dut (
    .s00_axi_aclk(aclk), .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .half(half), .half_sel(half_sel), .wr_err(wr_err)
  );

  // Half strobes are counted by select; each must coincide with bvalid.
  always @(negedge aclk) begin
    if (aresetn === 1'b1 && half === 1'b1) begin
      if (half_sel) hi_cnt++;
      else lo_cnt++;
      if (bvalid !== 1'b1) half_bad++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s timeout: got no handshake, expected one within 50 cycles", name);
  endtask

  // Assumes bready is high; returns the response captured when bvalid is seen.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    bit aw_go, w_go, aw_done, w_done;
    int n;
    resp = 2'bxx;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(negedge aclk);
      n++;
      if (aw_go) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (w_go)  begin wvalid  = 1'b0; w_done  = 1'b1; end
    end
    if (!(aw_done && w_done)) begin
      awvalid = 1'b0; wvalid = 1'b0;
      timeout_fail("write accept");
      return;
    end
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (bvalid !== 1'b1) begin timeout_fail("write response"); return; end
    resp = bresp;
    @(negedge aclk);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
    bit done;
    int n;
    d = 'x; r = 2'bxx;
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; done = 1'b0; n = 0;
    while (!done && n < 50) begin
      done = (arready === 1'b1);
      @(negedge aclk);
      n++;
    end
    arvalid = 1'b0;
    if (!done) begin timeout_fail("read accept"); return; end
    n = 0;
    while (rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
    if (rvalid !== 1'b1) begin timeout_fail("read response"); return; end
    d = rdata; r = rresp;
    @(negedge aclk);
  endtask

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [1:0]  eb;
    logic [31:0] ra;
    logic [31:0] ed;
    logic [1:0]  er;
    logic        ee;
    int          eh;
    logic        es;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  initial begin
    logic [1:0]  resp, rr;
    logic [31:0] rd;
    int h0, lo0, hi0, bad, stall_bad, acc_bad;

    vecs[0]  = '{32'h4000_0008, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h4000_0008, 32'hDEAD_BEEF, 2'b00, 1'b0, 0, 1'b0};
    vecs[1]  = '{32'h4000_000B, 32'h0102_0304, 4'h8, 2'b00, 32'h4000_0009, 32'h01AD_BEEF, 2'b00, 1'b0, 0, 1'b0};
    vecs[2]  = '{32'h4000_0000, 32'h0BAD_F00D, 4'hF, 2'b00, 32'h4000_0000, 32'h0BAD_F00D, 2'b00, 1'b0, 0, 1'b0};
    vecs[3]  = '{32'h4000_1000, 32'h1234_5678, 4'hF, 2'b10, 32'h4000_0000, 32'h0BAD_F00D, 2'b00, 1'b1, 0, 1'b0};
    vecs[4]  = '{32'h3FFF_FFFC, 32'h8765_4321, 4'hF, 2'b10, 32'h4000_1000, 32'h0000_0000, 2'b10, 1'b1, 0, 1'b0};
    vecs[5]  = '{32'h4000_0020, 32'hAAAA_5555, 4'hF, 2'b00, 32'h3FFF_FFFC, 32'h0000_0000, 2'b10, 1'b1, 0, 1'b0};
    vecs[6]  = '{32'h4000_0020, 32'h5555_5555, 4'h0, 2'b00, 32'h4000_0020, 32'hAAAA_5555, 2'b00, 1'b1, 0, 1'b0};
    vecs[7]  = '{32'h4000_0FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h4000_0FFC, 32'hCAFE_F00D, 2'b00, 1'b1, 1, 1'b1};
    vecs[8]  = '{32'h4000_07FC, 32'h1357_9BDF, 4'h0, 2'b00, 32'h4000_0FFC, 32'hCAFE_F00D, 2'b00, 1'b1, 0, 1'b0};
    vecs[9]  = '{32'h4000_07FC, 32'h2468_ACE0, 4'hF, 2'b00, 32'h4000_07FC, 32'h2468_ACE0, 2'b00, 1'b1, 1, 1'b0};
    vecs[10] = '{32'h4000_0FFC, 32'h0000_BEEF, 4'h3, 2'b00, 32'h4000_0FFC, 32'hCAFE_BEEF, 2'b00, 1'b1, 1, 1'b1};

    aresetn = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;

    // Reset values
    #3;
    check("reset readies", {awready, wready, arready}, 3'b000);
    check("reset valids", {bvalid, rvalid}, 2'b00);
    check("reset resps", {bresp, rresp}, 4'b0000);
    check("reset rdata", rdata, 32'h0);
    check("reset half/sel/err", {half, half_sel, wr_err}, 3'b000);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("ready before first clock", {awready, wready, arready}, 3'b000);
    @(negedge aclk);
    check("ready after first clock", {awready, wready, arready}, 3'b111);

    // AW three cycles ahead of W, partial strobe merge, write/read latency
    do_write(32'h4000_0010, 32'h1122_3344, 4'hF, resp);
    check("full write bresp", resp, 2'b00);
    @(negedge aclk);
    awaddr = 32'h4000_0010; awvalid = 1'b1;
    check("awready idle", awready, 1'b1);
    @(negedge aclk);
    awvalid = 1'b0;
    check("awready drops after AW", awready, 1'b0);
    check("wready holds before W", wready, 1'b1);
    @(negedge aclk);
    @(negedge aclk);
    wdata = 32'hAABB_CCDD; wstrb = 4'b0101; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    check("wready drops after W", wready, 1'b0);
    check("bvalid 1 cycle after W", bvalid, 1'b0);
    @(negedge aclk);
    check("bvalid 2 cycles after W", bvalid, 1'b1);
    check("partial write bresp", bresp, 2'b00);
    @(negedge aclk);
    check("bvalid consumed", bvalid, 1'b0);
    araddr = 32'h4000_0010; arvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid 1 cycle after AR", rvalid, 1'b0);
    @(negedge aclk);
    check("rvalid 2 cycles after AR", rvalid, 1'b1);
    check("partial merge rdata", rdata, 32'h11BB_33DD);
    check("partial merge rresp", rresp, 2'b00);
    @(negedge aclk);
    check("rvalid consumed", rvalid, 1'b0);

    // Table-driven write/read vectors
    for (int i = 0; i < NV; i++) begin
      h0 = lo_cnt + hi_cnt;
      do_write(vecs[i].wa, vecs[i].wd, vecs[i].ws, resp);
      check($sformatf("vec%0d bresp", i), resp, vecs[i].eb);
      do_read(vecs[i].ra, rd, rr);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].ed);
      check($sformatf("vec%0d rresp", i), rr, vecs[i].er);
      check($sformatf("vec%0d wr_err", i), wr_err, vecs[i].ee);
      check($sformatf("vec%0d half pulses", i), lo_cnt + hi_cnt - h0, vecs[i].eh);
      if (vecs[i].eh > 0) check($sformatf("vec%0d half_sel", i), half_sel, vecs[i].es);
    end

    // Fill the whole buffer with its index and read it all back
    lo0 = lo_cnt; hi0 = hi_cnt; bad = 0;
    for (int i = 0; i < 1024; i++) begin
      do_write(32'h4000_0000 + 32'(4 * i), 32'(i), 4'hF, resp);
      if (resp !== 2'b00) bad++;
      if (i == 511) check("fill half lower at 511", {lo_cnt - lo0, hi_cnt - hi0}, {32'd1, 32'd0});
    end
    check("fill bresp errors", bad, 0);
    check("fill lower pulses", lo_cnt - lo0, 1);
    check("fill upper pulses", hi_cnt - hi0, 1);
    check("fill final half_sel", half_sel, 1'b1);
    for (int i = 0; i < 1024; i++) begin
      do_read(32'h4000_0000 + 32'(4 * i), rd, rr);
      check($sformatf("fill read %0d", i), {rr, rd}, {2'b00, 32'(i)});
    end
    check("half without bvalid", half_bad, 0);

    // Back-pressure with a same-index write and read issued together
    bready = 1'b0; rready = 1'b0;
    @(negedge aclk);
    awaddr = 32'h4000_0008; wdata = 32'h0000_0077; wstrb = 4'hF; araddr = 32'h4000_0008;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    check("collision bvalid", bvalid, 1'b1);
    check("collision rvalid", rvalid, 1'b1);
    check("collision pre-write rdata", rdata, 32'd2);
    awaddr = 32'h4000_0100; araddr = 32'h4000_0100; awvalid = 1'b1; arvalid = 1'b1;
    stall_bad = 0; acc_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge aclk);
      if (bvalid !== 1'b1 || rvalid !== 1'b1 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'd2)
        stall_bad++;
      if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) acc_bad++;
    end
    check("stall outputs stable", stall_bad, 0);
    check("stall no new accept", acc_bad, 0);
    bready = 1'b1; rready = 1'b1; awvalid = 1'b0; arvalid = 1'b0;
    @(negedge aclk);
    check("stall completes on ready", {bvalid, rvalid}, 2'b00);
    do_read(32'h4000_0008, rd, rr);
    check("post-collision rdata", rd, 32'h0000_0077);

    // Reset asserted while in W_RESP with half high
    bready = 1'b0;
    @(negedge aclk);
    awaddr = 32'h4000_07FC; wdata = 32'hFEED_FACE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    check("pre-reset bvalid/half/err", {bvalid, half, wr_err}, 3'b111);
    #1 aresetn = 1'b0;
    #1;
    check("async reset bvalid", bvalid, 1'b0);
    check("async reset wr_err", wr_err, 1'b0);
    check("async reset half", half, 1'b0);
    check("async reset readies", {awready, wready, arready}, 3'b000);
    @(negedge aclk);
    @(negedge aclk);
    aresetn = 1'b1; bready = 1'b1;
    @(negedge aclk);
    check("readies after re-reset", {awready, wready, arready}, 3'b111);
    do_write(32'h4000_0300, 32'h3141_5926, 4'hF, resp);
    check("post-reset bresp", resp, 2'b00);
    do_read(32'h4000_0300, rd, rr);
    check("post-reset new data", rd, 32'h3141_5926);
    do_read(32'h4000_0008, rd, rr);
    check("post-reset old data", rd, 32'h0000_0077);
    do_read(32'h4000_07FC, rd, rr);
    check("post-reset interrupted write data", rd, 32'hFEED_FACE);
    check("post-reset wr_err", wr_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/acp_bram_slave.md
# acp_bram_slave

AXI4-Lite slave that terminates the ADC capture master's write stream in an on-chip word buffer and serves the same buffer to a reader over AXI4-Lite reads. It sits between the capture master's M00_AXI port and the CDMA read side. It raises a one-cycle half-complete strobe with a half select each time the last word of either buffer half is written, so CDMA kick-off can be driven from the responder end as well as the initiator end.

## Interface
- C_S00_AXI_BASE_ADDR, 32'h40000000, byte base address of the buffer window
- C_S00_AXI_ADDR_WIDTH, 32, AXI address width
- C_S00_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported
- C_S00_AXI_DEPTH, 1024, buffer depth in 32-bit words; power of two, ≥4
- s00_axi_aclk  in  1  single clock for all logic
- s00_axi_aresetn  in  1  asynchronous, active-low reset
- s00_axi_awaddr  in  ADDR_WIDTH  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid / s00_axi_awready  in / out  1  write address handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables
- s00_axi_wvalid / s00_axi_wready  in / out  1  write data handshake
- s00_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s00_axi_bvalid / s00_axi_bready  out / in  1  write response handshake
- s00_axi_araddr  in  ADDR_WIDTH  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid / s00_axi_arready  in / out  1  read address handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  read response: 00 OKAY, 10 SLVERR
- s00_axi_rvalid / s00_axi_rready  out / in  1  read data handshake
- half  out  1  one-cycle strobe: a buffer half has been completely written
- half_sel  out  1  half that just completed: 0 lower, 1 upper; held until the next strobe
- wr_err  out  1  sticky; set by any SLVERR write; cleared only by reset

## Operation
- Offset = addr − BASE. In range means 0 ≤ offset < 4·DEPTH. Word index = offset[log2(DEPTH)+1:2]. Low two address bits are ignored.
- Write channel has three states:
  - W_IDLE: awready=1 and wready=1. Each channel is accepted independently and its address or data/strobe is latched. When both are held, go to W_EXEC.
  - W_EXEC: exactly one cycle. If in range, write each byte lane whose wstrb bit is 1 and set bresp=OKAY. If out of range, write nothing, set bresp=SLVERR and set wr_err. Then go to W_RESP.
  - W_RESP: bvalid=1 until bready; then return to W_IDLE.
- awready drops after AW is captured and wready drops after W is captured; both reassert on return to W_IDLE. At most one write is outstanding.
- Half strobe: in W_EXEC, an in-range write with any wstrb bit set pulses half the following cycle.
  - Index DEPTH/2−1 pulses half with half_sel=0.
  - Index DEPTH−1 pulses half with half_sel=1.
  - Other indices do not pulse. Rewriting the same last word pulses again.
- Read channel has three states:
  - R_IDLE: arready=1. On handshake, latch the address and go to R_FETCH.
  - R_FETCH: one cycle of synchronous memory read. An out-of-range address returns rdata=0 and rresp=SLVERR. Go to R_RESP.
  - R_RESP: rvalid=1 with rdata/rresp held stable until rready; then return to R_IDLE.
- Read and write channels operate concurrently. If R_FETCH and W_EXEC hit the same index in the same cycle, the read returns the pre-write data.
- Buffer contents are not cleared by reset.

## Timing
- Reset values: awready=0, wready=0, arready=0, bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0, half=0, half_sel=0, wr_err=0. Ready signals go to 1 on the first clock after deassertion.
- Write latency: bvalid rises 2 cycles after the cycle in which both AW and W are held (1 cycle W_EXEC, then registered bvalid). half rises together with bvalid.
- Read latency: rvalid rises 2 cycles after the AR handshake.
- Back-to-back throughput: with bready and rready tied high, one write per 3 cycles and one read per 3 cycles.
- bvalid and rvalid never drop before their ready is seen.
- Reset mid-operation: FSMs return to IDLE immediately. Any in-flight response is dropped and half is forced to 0.

## Test plan
- Single write to 0x40000008, data 0xDEADBEEF, wstrb 4'hF; read back from 0x40000008 -> bresp=00, then rdata=0xDEADBEEF, rresp=00.
- AW sent 3 cycles before W, to 0x40000010 with data 0x11223344, then wstrb 4'b0101 writing 0xAABBCCDD to the same address -> read returns 0x11BB33DD; bvalid appears exactly 2 cycles after W accepted.
- Sequentially fill all 1024 words with data = index -> half pulses with half_sel=0 after index 511 and with half_sel=1 after index 1023, once each. Reading every word returns its index.
- Write to 0x40001000 (first word out of range) -> bresp=10, wr_err=1, no half pulse, memory unchanged. Read from the same address -> rresp=10, rdata=0.
- bready and rready held low for 10 cycles -> bvalid, rvalid, bresp, rdata stay stable, no new AW or AR is accepted, and completion occurs on the cycle ready rises.
- Assert s00_axi_aresetn low while in W_RESP -> bvalid, wr_err and half go to 0 asynchronously. After release, a fresh write completes normally and earlier buffer data is still readable.
